prog_fetch_ctrl: RTL and testbench

PROG_FETCH_CTRL -- requirements
Module: prog_fetch_ctrl

---
 rtl/prog_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_prog_fetch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/prog_fetch_ctrl.sv
// Program fetch controller for a registered program memory with a 1-cycle read latency.
// Runs one instruction per cycle and supports stall, jump with a one-cycle bubble, and halt on an opcode.
module prog_fetch_ctrl #(
  parameter int                   ADDR_WIDTH = 11,
  parameter int                   DATA_WIDTH = 16,
  parameter int                   OPC_WIDTH  = 5,
  parameter logic [OPC_WIDTH-1:0] HALT_OPC   = 5'b00000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stall,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_enb,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_instr_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_halted,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fp_q, fp_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic halt_det;
  logic mem_enb;
  logic instr_valid;
  logic take_jump;

  assign halt_det = (i_mem_data[DATA_WIDTH-1 -: OPC_WIDTH] == HALT_OPC);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    fp_d        = fp_q;
    pc_d        = pc_q;
    mem_enb     = 1'b0;
    instr_valid = 1'b0;
    take_jump   = 1'b0;

    case (state_q)
      S_IDLE: begin
        fp_d = '0;
        if (i_start) state_d = S_PRIME;
      end
      // Memory output is still stale here, so nothing issues and controls are ignored.
      S_PRIME: begin
        mem_enb = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (i_stall) begin
          state_d = S_RUN;
        end else if (halt_det) begin
          state_d = S_HALT;
        end else begin
          mem_enb     = 1'b1;
          instr_valid = 1'b1;
          if (i_jump) begin
            take_jump = 1'b1;
            state_d   = S_PRIME;
          end
        end
      end
      S_HALT: begin
        if (i_start) begin
          fp_d    = '0;
          state_d = S_PRIME;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The read issued this edge returns next cycle, so o_pc trails the fetch pointer by one.
    if (mem_enb) begin
      pc_d = fp_q;
      fp_d = take_jump ? i_jump_addr : fp_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      fp_q    <= '0;
      pc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q <= state_d;
      fp_q    <= fp_d;
      pc_q    <= pc_d;
    end
  end

  assign o_mem_addr    = fp_q;
  assign o_mem_enb     = mem_enb;
  assign o_instr       = i_mem_data;
  assign o_instr_valid = instr_valid;
  assign o_pc          = pc_q;
  assign o_halted      = (state_q == S_HALT);
  assign o_busy        = (state_q == S_PRIME) || (state_q == S_RUN);

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Self-checking bench for prog_fetch_ctrl: per-cycle vector table plus scoreboard of issued instructions.
module tb_prog_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_stall;
  logic        i_jump;
  logic [10:0] i_jump_addr;
  logic [15:0] mem_rd;
  logic [10:0] o_mem_addr;
  logic        o_mem_enb;
  logic [15:0] o_instr;
  logic        o_instr_valid;
  logic [10:0] o_pc;
  logic        o_halted;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:2047];
  logic [10:0] sb_q[$];

  typedef struct {
    logic        start;
    logic        stall;
    logic        jump;
    logic [10:0] jaddr;
    logic        exp_valid;
    logic        exp_enb;
    logic        exp_halted;
    logic        exp_busy;
    logic [10:0] exp_pc;
    logic [10:0] exp_addr;
  } vec_t;

  vec_t tbl[20];

  prog_fetch_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (i_start),
    .i_stall      (i_stall),
    .i_jump       (i_jump),
    .i_jump_addr  (i_jump_addr),
    .i_mem_data   (mem_rd),
    .o_mem_addr   (o_mem_addr),
    .o_mem_enb    (o_mem_enb),
    .o_instr      (o_instr),
    .o_instr_valid(o_instr_valid),
    .o_pc         (o_pc),
    .o_halted     (o_halted),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered program memory: output updates only on enabled edges.
  always @(posedge clk) if (o_mem_enb) mem_rd <= mem[o_mem_addr];

  function automatic vec_t mk(input logic st, input logic sl, input logic jp, input logic [10:0] ja,
                              input logic ev, input logic ee, input logic eh, input logic eb,
                              input logic [10:0] ep, input logic [10:0] ea);
    vec_t v;
    v.start = st; v.stall = sl; v.jump = jp; v.jaddr = ja;
    v.exp_valid = ev; v.exp_enb = ee; v.exp_halted = eh; v.exp_busy = eb;
    v.exp_pc = ep; v.exp_addr = ea;
    return v;
  endfunction

  function automatic vec_t run(input logic [10:0] pc);
    return mk(1'b0, 1'b0, 1'b0, 11'h0, 1'b1, 1'b1, 1'b0, 1'b1, pc, pc + 11'h1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negative edge: drive inputs, compare, then advance to the next negative edge.
  task automatic apply(input vec_t v);
    logic [10:0] exp_pc;
    i_start     = v.start;
    i_stall     = v.stall;
    i_jump      = v.jump;
    i_jump_addr = v.jaddr;
    if (v.exp_valid) sb_q.push_back(v.exp_pc);
    #1;
    check("instr_valid", 32'(o_instr_valid), 32'(v.exp_valid));
    check("mem_enb",     32'(o_mem_enb),     32'(v.exp_enb));
    check("halted",      32'(o_halted),      32'(v.exp_halted));
    check("busy",        32'(o_busy),        32'(v.exp_busy));
    check("pc",          32'(o_pc),          32'(v.exp_pc));
    check("mem_addr",    32'(o_mem_addr),    32'(v.exp_addr));
    if (o_instr_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: issued pc %0h with no expected entry", o_pc);
      end else begin
        exp_pc = sb_q.pop_front();
        check("sb_pc",    32'(o_pc),    32'(exp_pc));
        check("sb_instr", 32'(o_instr), 32'(mem[exp_pc]));
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enb"},   32'(o_mem_enb),     32'd0);
    check({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
    check({tag, "_halt"},  32'(o_halted),      32'd0);
    check({tag, "_busy"},  32'(o_busy),        32'd0);
    check({tag, "_pc"},    32'(o_pc),          32'd0);
    check({tag, "_addr"},  32'(o_mem_addr),    32'd0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = {5'h1, 11'(a)};

    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 11'h055, 1'b0, 1'b1, 1'b0, 1'b1, 11'h000, 11'h000);
    for (int k = 0; k < 5; k++) tbl[2 + k] = run(11'(k));
    for (int k = 7; k < 10; k++)
      tbl[k] = mk(1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1, 11'h005, 11'h006);
    tbl[10] = run(11'h005);
    tbl[11] = run(11'h006);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 11'h7FE, 1'b1, 1'b1, 1'b0, 1'b1, 11'h007, 11'h008);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 11'h008, 11'h7FE);
    tbl[14] = run(11'h7FE);
    tbl[15] = run(11'h7FF);
    tbl[16] = run(11'h000);
    tbl[17] = mk(1'b0, 1'b1, 1'b1, 11'h300, 1'b0, 1'b0, 1'b0, 1'b1, 11'h001, 11'h002);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 1'b1, 11'h001, 11'h002);
    tbl[19] = run(11'h002);

    rst_n = 1'b0; i_start = 1'b0; i_stall = 1'b0; i_jump = 1'b0; i_jump_addr = '0;
    @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // Jump issued while pc=3: one bubble, then the target sequence.
    apply(mk(1'b0, 1'b0, 1'b1, 11'h7F0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h003, 11'h004));
    apply(mk(1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 11'h004, 11'h7F0));
    apply(run(11'h7F0));
    apply(run(11'h7F1));

    // Asynchronous reset in the middle of a cycle while running.
    i_start = 1'b0; i_stall = 1'b0; i_jump = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    i_start = 1'b0;
    rst_n   = 1'b1;
    apply(mk(1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000));

    // Halt opcode at address 4, then restart from HALT.
    mem[4] = 16'h0000;
    apply(mk(1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000));
    apply(mk(1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 11'h000, 11'h000));
    for (int k = 0; k < 4; k++) apply(run(11'(k)));
    apply(mk(1'b0, 1'b0, 1'b1, 11'h100, 1'b0, 1'b0, 1'b0, 1'b1, 11'h004, 11'h005));
    apply(mk(1'b0, 1'b1, 1'b1, 11'h123, 1'b0, 1'b0, 1'b1, 1'b0, 11'h004, 11'h005));
    apply(mk(1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 1'b0, 11'h004, 11'h005));
    apply(mk(1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1, 11'h004, 11'h000));
    apply(run(11'h000));
    apply(run(11'h001));

    check("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
